// File: rtl/hazard_forward_unit.sv
// -----------------------------------------------------------------------------
// hazard_forward_unit
//
// Hazard controller for the 5-stage IF/ID/EX/MEM/WB pipeline. It keeps a
// shadow copy of the destination register, write-enable and load flags of the
// instructions in EX, MEM and WB, and from those it decides, in the same cycle:
//   - which pipeline stage supplies each EX operand (forwarding),
//   - whether a load-use hazard needs one bubble (PC and IF/ID frozen,
//     decoder output forced to NOP),
//   - whether the instruction fetched past a taken CTI's delay slot must be
//     flushed from IF/ID.
//
// Optional feature: define HAZ_PERF_CNT_EN to build saturating stall/flush
// performance counters. When it is undefined, both counter outputs are tied
// to zero and no counter flops exist.
//
// Ports
//   clk, rst_n        rising-edge clock, synchronous active-low reset
//   id_valid          ID holds a real instruction
//   id_rs1, id_rs2    ID source registers; id_use_rs2 = rs2 is actually read
//   id_rd, id_rf_le   ID destination register and its write enable
//   id_load, id_cti   ID instruction is a load / branch, call or jmpl
//   ex_taken          CTI in EX resolved taken (meaningful in CTI_EX only)
//   fwd_a_sel/b_sel   EX operand source: 00 RF, 01 EX, 10 MEM, 11 WB
//   pc_le, ifid_le    PC and IF/ID load enables
//   id_bubble         force decoder outputs to NOP into ID/EX
//   ifid_flush        clear IF/ID to NOP on the next edge
//   stall_cnt         load-use stall cycles (saturating)
//   flush_cnt         taken-CTI flush cycles (saturating)
// -----------------------------------------------------------------------------
module hazard_forward_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_rf_le,
  input  logic             id_load,
  input  logic             id_cti,
  input  logic             ex_taken,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             pc_le,
  output logic             ifid_le,
  output logic             id_bubble,
  output logic             ifid_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {
    RUN    = 1'b0,
    CTI_EX = 1'b1
  } state_t;

  // Shadow pipeline state. A load flag is kept only for EX: once a load
  // reaches MEM its data is available there, so MEM/WB need no load marker.
  logic [4:0] ex_rd, mem_rd, wb_rd;
  logic       ex_we, mem_we, wb_we;
  logic       ex_load;

  state_t     state_q, state_d;
  logic       stall;
  logic       cti_advance;

  // Priority EX > MEM > WB. Register 0 never forwards: a zero source returns
  // RF, and a stage whose rd is 0 cannot match a non-zero source.
  function automatic logic [1:0] fwd_select(
    input logic [4:0] src,
    input logic       e_we, input logic [4:0] e_rd,
    input logic       m_we, input logic [4:0] m_rd,
    input logic       w_we, input logic [4:0] w_rd
  );
    if (src == 5'd0)                 return 2'b00;
    else if (e_we && (e_rd == src))  return 2'b01;
    else if (m_we && (m_rd == src))  return 2'b10;
    else if (w_we && (w_rd == src))  return 2'b11;
    else                             return 2'b00;
  endfunction

  // Combinational decisions. Every output is forced to its reset value while
  // rst_n is low so nothing from the aborted operation leaks out.
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    stall     = 1'b0;
    fwd_a_sel = 2'b00;
    fwd_b_sel = 2'b00;
    if (rst_n) begin
      stall = id_valid && ex_load && ex_we &&
              (((id_rs1 != 5'd0) && (ex_rd == id_rs1)) ||
               (id_use_rs2 && (id_rs2 != 5'd0) && (ex_rd == id_rs2)));
      fwd_a_sel = fwd_select(id_rs1, ex_we, ex_rd, mem_we, mem_rd, wb_we, wb_rd);
      if (id_use_rs2)
        fwd_b_sel = fwd_select(id_rs2, ex_we, ex_rd, mem_we, mem_rd, wb_we, wb_rd);
    end
  end

  assign pc_le       = ~stall;
  assign ifid_le     = ~stall;
  assign id_bubble   = stall;
  assign cti_advance = id_valid & id_cti & ~stall;

  // CTI sequencing: the cycle after a CTI leaves ID it sits in EX with its
  // delay slot in ID; only then is ex_taken meaningful. A CTI in the delay
  // slot keeps the sequencer in CTI_EX for another cycle.
  always_comb begin
    state_d    = state_q;
    ifid_flush = 1'b0;
    unique case (state_q)
      RUN: begin
        if (cti_advance) state_d = CTI_EX;
      end
      CTI_EX: begin
        ifid_flush = ex_taken & rst_n;
        state_d    = cti_advance ? CTI_EX : RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of the others, exactly like the EX->MEM->WB shift.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      ex_rd   <= 5'd0;
      ex_we   <= 1'b0;
      ex_load <= 1'b0;
      mem_rd  <= 5'd0;
      mem_we  <= 1'b0;
      wb_rd   <= 5'd0;
      wb_we   <= 1'b0;
    end else begin
      state_q <= state_d;
      // A bubble enters EX as a non-writing, non-load slot.
      ex_rd   <= id_rd;
      ex_we   <= id_valid & id_rf_le & ~stall;
      ex_load <= id_valid & id_load & ~stall;
      mem_rd  <= ex_rd;
      mem_we  <= ex_we;
      wb_rd   <= mem_rd;
      wb_we   <= mem_we;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (id_bubble && (stall_q != '1))  stall_q <= stall_q + 1'b1;
      if (ifid_flush && (flush_q != '1)) flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
